// File: rtl/psr1_sched_pkg.sv
// rtl/psr1_sched_pkg.sv - shared types and sizing helpers for the split-pulse scheduler
package psr1_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GUARD = 2'd2
  } state_e;

  // One timer covers both the pulse and the guard phase, loaded with (length - 1).
  function automatic int timer_w(input int pulse_w, input int guard);
    int m;
    m = (pulse_w > guard) ? pulse_w : guard;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/psr1_rr_arb.sv
// rtl/psr1_rr_arb.sv - combinational round-robin pick starting just after ptr
module psr1_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_idx
);

  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    idx       = 0;
    sel       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      sel = ID_W'(idx);
      if (!gnt_valid && req[sel]) begin
        gnt_valid = 1'b1;
        gnt_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/psr1_split_sched.sv
// rtl/psr1_split_sched.sv - shares one splitter input among requesters with fixed pulse and guard timing
module psr1_split_sched
  import psr1_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 2,
  parameter int GUARD   = 10,
  parameter int CNT_W   = 16,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             split_in,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam int            TW         = timer_w(PULSE_W, GUARD);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] GUARD_LOAD = TW'((GUARD > 0) ? GUARD - 1 : 0);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              split_q, split_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_idx;
  logic              grant_go;

  psr1_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Requests are only looked at in IDLE; PULSE and GUARD run to completion.
  assign grant_go = (state_q == S_IDLE) && enable && gnt_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
      split_q <= 1'b0;
      ack_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      split_q <= split_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (grant_go) begin
          state_d = S_PULSE;
          timer_d = PULSE_LOAD;
        end
      end
      S_PULSE: begin
        if (timer_q == '0) begin
          if (GUARD > 0) begin
            state_d = S_GUARD;
            timer_d = GUARD_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_GUARD: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    split_d = (state_d == S_PULSE);
    busy_d  = (state_d != S_IDLE);
    ack_d   = '0;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (grant_go) begin
      ack_d = N_REQ'(1) << gnt_idx;
      gid_d = gnt_idx;
      ptr_d = gnt_idx;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign ack       = ack_q;
  assign split_in  = split_q;
  assign grant_id  = gid_q;
  assign busy      = busy_q;
  assign pulse_cnt = cnt_q;

endmodule
